pargen_stream: RTL and testbench
================================

# pargen_stream

Parametrised, pipelined parity generator for word streams; the successor to the fixed 3-input combinational parity generator. Accepts WIDTH-bit words over a valid/ready handshake and appends a per-word parity bit (odd or even, selected by parameter). It also accumulates frame-level parity and word count across multi-word frames delimited by `in_last`. It sits between a data source and a serial link or storage writer that needs parity-protected words and a per-frame check value.

## Interface
- `WIDTH`, 8: data word width, ≥1.
- `ODD`, 1: 1 = odd parity (all-zero word gives parity 1), 0 = even parity (all-zero word gives parity 0).
- `LEN_W`, 8: width of the frame word counter, ≥1.
- `clk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  WIDTH  input word.
- `in_last`  in  1  word is the final word of its frame.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  sink accepts the output word.
- `out_data`  out  WIDTH+1  {parity, data}; parity is the MSB.
- `out_last`  out  1  registered copy of `in_last`.
- `out_frame_par`  out  1  frame parity; meaningful only when `out_valid && out_last`, 0 otherwise.
- `out_frame_len`  out  LEN_W  words in the frame, including the last; meaningful only when `out_valid && out_last`, 0 otherwise.

## Operation
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Word parity: `par = (^in_data) ^ ODD`. This reproduces the original 3-bit truth table when `WIDTH=3, ODD=1`.
- Frame accumulator `acc` (1 bit) holds the XOR of all data bits accepted so far in the open frame.
- Frame counter `cnt` (LEN_W bits) counts words accepted so far in the open frame.
- FSM states:
  - IDLE: no open frame. `acc=0`, `cnt=0`.
  - FRAME: at least one non-last word has been accepted.
- Transitions, on an input transfer:
  - IDLE, `in_last=0` → FRAME.
  - IDLE, `in_last=1` → IDLE. This is a single-word frame.
  - FRAME, `in_last=0` → FRAME.
  - FRAME, `in_last=1` → IDLE.
  - No transfer → state unchanged.
- On a non-last transfer: `acc <= acc ^ (^in_data)`, and `cnt <=` `cnt+1`, saturating at 2^LEN_W−1.
- On a last transfer:
  - Output register loads `out_frame_par = acc ^ (^in_data) ^ ODD`.
  - Output register loads `out_frame_len = sat(cnt+1)`.
  - Then `acc <= 0`, `cnt <= 0`.
- On a non-last transfer, the output register loads `out_frame_par=0` and `out_frame_len=0`.
- Saturation: when `cnt` already equals all ones, it holds there. A frame of 2^LEN_W or more words reports all ones.
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `out_frame_par=0`, `out_frame_len=0`, state IDLE, `acc=0`, `cnt=0`. `in_ready` is 1 in the cycle after reset.
- Reset mid-frame discards the open frame and any held output word. There is no partial-frame report.
- `in_data`/`in_last` are ignored when `in_valid=0`. Values of `in_data` with `in_valid=0` must not affect `acc`.

## Timing
- Single output register stage: latency is 1 cycle from input transfer to `out_valid`.
- `in_ready = !out_valid || out_ready`. This is combinational from `out_ready`, with no combinational path from `in_valid` to `in_ready`.
- Throughput is 1 word/cycle with `out_ready` held high.
- Simultaneous output transfer and input transfer in the same cycle: the register reloads with the new word and `out_valid` stays 1.
- Output transfer with no input transfer: `out_valid <= 0`.
- While `out_valid && !out_ready`, all `out_*` signals hold stable, and `in_ready=0`.

## Structure
- Package `pargen_pkg`:
  - FSM state enum `{IDLE, FRAME}`.
  - Function `calc_par(data, odd)`, generic over width via parameterised use.
  - Saturating-increment helper.
- One natural sub-module: `pargen_word`, a combinational WIDTH-generic parity reducer with an ODD parameter. It is instantiated once for the word parity. The frame path reuses its even-parity result.
- Target size is roughly 150–250 lines of RTL.

## Test plan
- Exhaustive single-word frames, `WIDTH=3, ODD=1`, `in_last=1`, all 8 inputs, `out_ready=1`:
  - Outputs (MSB first) are `1000, 0001, 0010, 1011, 0100, 1101, 1110, 0111`.
  - `out_frame_len=1` on every word.
  - `out_frame_par` equals the MSB on every word.
- `WIDTH=8, ODD=0`, frame of 0x01, 0x03, 0x80 (last), streamed back-to-back:
  - Word parities are 1, 0, 1.
  - Last beat gives `out_frame_par=0`, `out_frame_len=3`.
  - `out_valid` stays high for 3 consecutive cycles.
- Backpressure: hold `out_ready=0` for 4 cycles while `in_valid=1`.
  - After the first word, `in_ready=0`.
  - `out_data` is stable.
  - Releasing `out_ready` resumes 1 word/cycle with no loss or duplication.
- Saturation, `LEN_W=2`: a 6-word frame reports `out_frame_len=3`. The next 2-word frame reports `out_frame_len=2`.
- Reset mid-frame: after 2 non-last words, pulse `rst` for 1 cycle.
  - Next cycle, all outputs are 0 and `in_ready=1`.
  - A following single-word frame 0x00 with `ODD=1` gives `out_frame_par=1`, `out_frame_len=1`.

Source files
------------

// File: rtl/pargen_pkg.sv
// Shared types and helpers for the pargen_stream parity generator.
// Widths are bounded by PAR_MAX_W (data) and CNT_MAX_W (frame counter).
package pargen_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  localparam int unsigned PAR_MAX_W = 256;
  localparam int unsigned CNT_MAX_W = 32;

  // Zero-extension leaves the XOR reduction unchanged, so one function serves every width.
  function automatic logic calc_par(input logic [PAR_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] value,
                                                   input logic [CNT_MAX_W-1:0] max);
    return (value >= max) ? max : value + CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/pargen_word.sv
// Combinational WIDTH-generic parity reducer: selected-sense parity plus the raw even parity.
module pargen_word
  import pargen_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter bit          ODD   = 1'b1
) (
  input  logic [WIDTH-1:0] data,
  output logic             par,
  output logic             par_even
);

  logic [PAR_MAX_W-1:0] data_ext;

  assign data_ext = PAR_MAX_W'(data);
  assign par_even = calc_par(data_ext, 1'b0);
  assign par      = par_even ^ ODD;

endmodule

// File: rtl/pargen_stream.sv
// Pipelined word-stream parity generator with per-frame parity and word count.
// One output register stage; in_ready depends only on out_valid and out_ready.
module pargen_stream
  import pargen_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter bit          ODD   = 1'b1,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_data,
  output logic             out_last,
  output logic             out_frame_par,
  output logic [LEN_W-1:0] out_frame_len
);

  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             acc_base;
  logic [LEN_W-1:0] cnt_base, cnt_inc;
  logic             frame_par_d;
  logic [LEN_W-1:0] frame_len_d;
  logic             word_par, word_par_even;
  logic             in_fire, out_fire;

  pargen_word #(
    .WIDTH (WIDTH),
    .ODD   (ODD)
  ) u_word (
    .data     (in_data),
    .par      (word_par),
    .par_even (word_par_even)
  );

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    state_d = state_q;
    if (in_fire) begin
      state_d = in_last ? IDLE : FRAME;
    end
  end

  // A frame always restarts from zero in IDLE, regardless of accumulator contents.
  assign acc_base = (state_q == FRAME) ? acc_q : 1'b0;
  assign cnt_base = (state_q == FRAME) ? cnt_q : '0;
  assign cnt_inc  = LEN_W'(sat_inc(CNT_MAX_W'(cnt_base), CNT_MAX_W'(CNT_MAX)));

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    frame_par_d = 1'b0;
    frame_len_d = '0;
    if (in_fire) begin
      if (in_last) begin
        frame_par_d = acc_base ^ word_par_even ^ ODD;
        frame_len_d = cnt_inc;
        acc_d       = 1'b0;
        cnt_d       = '0;
      end else begin
        acc_d = acc_base ^ word_par_even;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      out_frame_par <= 1'b0;
      out_frame_len <= '0;
    end else if (in_fire) begin
      out_valid     <= 1'b1;
      out_data      <= {word_par, in_data};
      out_last      <= in_last;
      out_frame_par <= frame_par_d;
      out_frame_len <= frame_len_d;
    end else if (out_fire) begin
      // Frame fields read as zero whenever no last word is being presented.
      out_valid     <= 1'b0;
      out_frame_par <= 1'b0;
      out_frame_len <= '0;
    end
  end

endmodule

// File: tb/tb_pargen_stream.sv
// Directed self-checking bench for pargen_stream using four parameterisations.
module tb_pargen_stream;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // a: WIDTH=3 ODD=1 LEN_W=8
  logic       a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_last, a_fpar;
  logic [2:0] a_in_data;
  logic [3:0] a_out_data;
  logic [7:0] a_flen;
  // b: WIDTH=8 ODD=0 LEN_W=8
  logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last, b_fpar;
  logic [7:0] b_in_data;
  logic [8:0] b_out_data;
  logic [7:0] b_flen;
  // c: WIDTH=8 ODD=0 LEN_W=2
  logic       c_in_valid, c_in_ready, c_in_last, c_out_valid, c_out_ready, c_out_last, c_fpar;
  logic [7:0] c_in_data;
  logic [8:0] c_out_data;
  logic [1:0] c_flen;
  // d: WIDTH=8 ODD=1 LEN_W=8
  logic       d_in_valid, d_in_ready, d_in_last, d_out_valid, d_out_ready, d_out_last, d_fpar;
  logic [7:0] d_in_data;
  logic [8:0] d_out_data;
  logic [7:0] d_flen;

  pargen_stream #(.WIDTH(3), .ODD(1'b1), .LEN_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_last(a_in_last), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .out_frame_par(a_fpar), .out_frame_len(a_flen));

  pargen_stream #(.WIDTH(8), .ODD(1'b0), .LEN_W(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .out_frame_par(b_fpar), .out_frame_len(b_flen));

  pargen_stream #(.WIDTH(8), .ODD(1'b0), .LEN_W(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_last(c_in_last), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_last(c_out_last), .out_frame_par(c_fpar), .out_frame_len(c_flen));

  pargen_stream #(.WIDTH(8), .ODD(1'b1), .LEN_W(8)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .in_last(d_in_last), .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
    .out_last(d_out_last), .out_frame_par(d_fpar), .out_frame_len(d_flen));

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b_out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({b_out_valid, b_out_data, b_out_last, b_fpar, b_flen} !== 20'd0) begin
      errors++; $display("FAIL reset_outputs_b: got %h expected 0",
                         {b_out_valid, b_out_data, b_out_last, b_fpar, b_flen});
    end
    checks++;
    if (b_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready_b: got %b expected 1", b_in_ready);
    end
    checks++;
    if ({a_out_valid, a_out_data, a_fpar, a_flen} !== 14'd0) begin
      errors++; $display("FAIL reset_outputs_a: got %h expected 0", {a_out_valid, a_out_data, a_fpar, a_flen});
    end
    b_out_ready = 1'b1;
  endtask

  task automatic test_exhaustive_w3();
    logic [3:0] exp_tab [8] = '{4'b1000, 4'b0001, 4'b0010, 4'b1011,
                                4'b0100, 4'b1101, 4'b1110, 4'b0111};
    logic [3:0] e;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_last   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in_data = 3'(i);
      tick();
      e = exp_tab[i];
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== e) begin
        errors++; $display("FAIL w3_word_%0d: got v=%b d=%b expected v=1 d=%b", i, a_out_valid, a_out_data, e);
      end
      checks++;
      if (a_flen !== 8'd1 || a_fpar !== e[3] || a_out_last !== 1'b1) begin
        errors++; $display("FAIL w3_frame_%0d: got len=%0d par=%b last=%b expected len=1 par=%b last=1",
                           i, a_flen, a_fpar, a_out_last, e[3]);
      end
    end
    a_in_valid = 1'b0;
    tick();
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL w3_drain: got out_valid=%b expected 0", a_out_valid);
    end
  endtask

  task automatic test_frame_w8();
    logic [7:0] words [3] = '{8'h01, 8'h03, 8'h80};
    logic [8:0] exp_d [3] = '{9'h101, 9'h003, 9'h180};
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_in_data = words[i];
      b_in_last = (i == 2);
      tick();
      checks++;
      if (b_out_valid !== 1'b1 || b_out_data !== exp_d[i]) begin
        errors++; $display("FAIL frame_word_%0d: got v=%b d=%h expected v=1 d=%h", i, b_out_valid, b_out_data, exp_d[i]);
      end
      if (i < 2) begin
        checks++;
        if (b_out_last !== 1'b0 || b_fpar !== 1'b0 || b_flen !== 8'd0) begin
          errors++; $display("FAIL frame_nonlast_%0d: got last=%b par=%b len=%0d expected 0 0 0",
                             i, b_out_last, b_fpar, b_flen);
        end
      end
    end
    checks++;
    if (b_out_last !== 1'b1 || b_fpar !== 1'b0 || b_flen !== 8'd3) begin
      errors++; $display("FAIL frame_last: got last=%b par=%b len=%0d expected last=1 par=0 len=3",
                         b_out_last, b_fpar, b_flen);
    end
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
    tick();
  endtask

  task automatic test_ignore_invalid();
    b_in_valid = 1'b1; b_in_data = 8'h01; b_in_last = 1'b0;
    tick();
    b_in_valid = 1'b0; b_in_data = 8'hFF; b_in_last = 1'b1;
    tick();
    checks++;
    if (b_out_valid !== 1'b0) begin
      errors++; $display("FAIL gap_valid: got out_valid=%b expected 0", b_out_valid);
    end
    b_in_data = 8'h01;
    tick();
    b_in_valid = 1'b1; b_in_data = 8'h00; b_in_last = 1'b1;
    tick();
    checks++;
    if (b_out_data !== 9'h000 || b_fpar !== 1'b1 || b_flen !== 8'd2) begin
      errors++; $display("FAIL gap_frame: got d=%h par=%b len=%0d expected d=000 par=1 len=2",
                         b_out_data, b_fpar, b_flen);
    end
    b_in_valid = 1'b0; b_in_last = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] words [4] = '{8'h5A, 8'h0F, 8'h07, 8'hFF};
    logic [8:0] exp_d [4] = '{9'h05A, 9'h00F, 9'h107, 9'h0FF};
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_last   = 1'b0;
    b_in_data   = words[0];
    tick();
    b_in_data = words[1];
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (b_out_valid !== 1'b1 || b_out_data !== exp_d[0] || b_in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d: got v=%b d=%h rdy=%b expected v=1 d=%h rdy=0",
                           k, b_out_valid, b_out_data, b_in_ready, exp_d[0]);
      end
      tick();
    end
    b_out_ready = 1'b1;
    #1;
    checks++;
    if (b_in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_comb: got in_ready=%b expected 1", b_in_ready);
    end
    for (int i = 1; i < 4; i++) begin
      b_in_data = words[i];
      b_in_last = (i == 3);
      tick();
      checks++;
      if (b_out_valid !== 1'b1 || b_out_data !== exp_d[i]) begin
        errors++; $display("FAIL bp_resume_%0d: got v=%b d=%h expected v=1 d=%h", i, b_out_valid, b_out_data, exp_d[i]);
      end
    end
    checks++;
    if (b_fpar !== 1'b1 || b_flen !== 8'd4) begin
      errors++; $display("FAIL bp_frame: got par=%b len=%0d expected par=1 len=4", b_fpar, b_flen);
    end
    b_in_valid = 1'b0; b_in_last = 1'b0;
    tick();
    checks++;
    if (b_out_valid !== 1'b0 || b_flen !== 8'd0) begin
      errors++; $display("FAIL bp_drain: got v=%b len=%0d expected v=0 len=0", b_out_valid, b_flen);
    end
  endtask

  task automatic test_saturation();
    c_out_ready = 1'b1;
    c_in_valid  = 1'b1;
    c_in_data   = 8'h01;
    for (int i = 0; i < 6; i++) begin
      c_in_last = (i == 5);
      tick();
    end
    checks++;
    if (c_out_last !== 1'b1 || c_flen !== 2'd3 || c_fpar !== 1'b0) begin
      errors++; $display("FAIL sat_len: got last=%b len=%0d par=%b expected last=1 len=3 par=0",
                         c_out_last, c_flen, c_fpar);
    end
    c_in_data = 8'h03; c_in_last = 1'b0;
    tick();
    checks++;
    if (c_flen !== 2'd0 || c_out_data !== 9'h003) begin
      errors++; $display("FAIL sat_next_first: got len=%0d d=%h expected len=0 d=003", c_flen, c_out_data);
    end
    c_in_data = 8'h01; c_in_last = 1'b1;
    tick();
    checks++;
    if (c_flen !== 2'd2 || c_fpar !== 1'b1) begin
      errors++; $display("FAIL sat_next_len: got len=%0d par=%b expected len=2 par=1", c_flen, c_fpar);
    end
    c_in_valid = 1'b0; c_in_last = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    d_out_ready = 1'b1;
    d_in_valid  = 1'b1;
    d_in_last   = 1'b0;
    d_in_data   = 8'h01;
    tick();
    d_in_data = 8'h03;
    tick();
    d_in_valid  = 1'b0;
    d_out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({d_out_valid, d_out_data, d_out_last, d_fpar, d_flen} !== 20'd0) begin
      errors++; $display("FAIL rstmid_outputs: got %h expected 0", {d_out_valid, d_out_data, d_out_last, d_fpar, d_flen});
    end
    checks++;
    if (d_in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_in_ready: got %b expected 1", d_in_ready);
    end
    d_out_ready = 1'b1;
    d_in_valid  = 1'b1;
    d_in_last   = 1'b1;
    d_in_data   = 8'h00;
    tick();
    checks++;
    if (d_out_data !== 9'h100 || d_fpar !== 1'b1 || d_flen !== 8'd1) begin
      errors++; $display("FAIL rstmid_frame: got d=%h par=%b len=%0d expected d=100 par=1 len=1",
                         d_out_data, d_fpar, d_flen);
    end
    d_in_valid = 1'b0; d_in_last = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_last = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_last = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_last = 1'b0; c_in_data = '0; c_out_ready = 1'b1;
    d_in_valid = 1'b0; d_in_last = 1'b0; d_in_data = '0; d_out_ready = 1'b1;
    test_reset();
    test_exhaustive_w3();
    test_frame_w8();
    test_ignore_invalid();
    test_backpressure();
    test_saturation();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
